// File: rtl/bsg_fifos_packet_arbiter.sv
// Round-robin, whole-packet arbiter sharing one credit-gated downstream link
// among several tx FIFO outputs; a slot holds the link for exactly packet_words_p words.
module bsg_fifos_packet_arbiter #(
    parameter int num_slots_p    = 2,
    parameter int width_p        = 32,
    parameter int packet_words_p = 4,
    parameter int credits_p      = 16,
    localparam int slot_w_lp     = (num_slots_p > 1) ? $clog2(num_slots_p) : 1,
    localparam int cred_w_lp     = $clog2(credits_p + 1)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [num_slots_p-1:0]         fifo_v_i,
    input  logic [num_slots_p*width_p-1:0] fifo_data_i,
    output logic [num_slots_p-1:0]         fifo_yumi_o,
    output logic                           v_o,
    output logic [width_p-1:0]             data_o,
    input  logic                           ready_i,
    input  logic                           credit_return_i,
    output logic [slot_w_lp-1:0]           slot_o,
    output logic [cred_w_lp-1:0]           credits_o,
    output logic                           busy_o
);

    localparam int cnt_w_lp = (packet_words_p > 1) ? $clog2(packet_words_p) : 1;
    localparam logic [cred_w_lp-1:0] pkt_credits_lp = cred_w_lp'(packet_words_p);
    localparam logic [cred_w_lp-1:0] credits_max_lp = cred_w_lp'(credits_p);
    localparam logic [cnt_w_lp-1:0]  last_word_lp   = cnt_w_lp'(packet_words_p - 1);
    localparam logic [slot_w_lp-1:0] last_slot_lp   = slot_w_lp'(num_slots_p - 1);

    typedef enum logic {IDLE, SEND} state_e;

    state_e                 state_r, state_n;
    logic [slot_w_lp-1:0]   rr_ptr_r, rr_ptr_n;
    logic [slot_w_lp-1:0]   grant_r, grant_n;
    logic [slot_w_lp-1:0]   pick;
    logic [cnt_w_lp-1:0]    word_cnt_r, word_cnt_n;
    logic [cred_w_lp-1:0]   credits_r, credits_n;
    logic                   found;
    logic                   sel_v;
    logic [width_p-1:0]     sel_data;
    logic                   ret_ok;

    // First valid slot starting from rr_ptr, wrapping around
    always_comb begin
        logic [slot_w_lp-1:0] idx;
        idx   = '0;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < num_slots_p; i++) begin
            idx = slot_w_lp'((32'(rr_ptr_r) + 32'(i)) % num_slots_p);
            if (!found && fifo_v_i[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        sel_v    = 1'b0;
        sel_data = '0;
        for (int i = 0; i < num_slots_p; i++) begin
            if (grant_r == slot_w_lp'(i)) begin
                sel_v    = fifo_v_i[i];
                sel_data = fifo_data_i[i*width_p +: width_p];
            end
        end
    end

    always_comb begin
        state_n     = state_r;
        rr_ptr_n    = rr_ptr_r;
        grant_n     = grant_r;
        word_cnt_n  = word_cnt_r;
        credits_n   = credits_r;
        v_o         = 1'b0;
        data_o      = '0;
        fifo_yumi_o = '0;
        // A return at full credit is a protocol error and is dropped
        ret_ok      = credit_return_i && (credits_r != credits_max_lp);
        case (state_r)
            IDLE: begin
                if (found && (credits_r >= pkt_credits_lp)) begin
                    grant_n    = pick;
                    credits_n  = credits_r - pkt_credits_lp;
                    word_cnt_n = '0;
                    state_n    = SEND;
                end
            end
            SEND: begin
                v_o    = sel_v;
                data_o = sel_data;
                if (sel_v && ready_i) begin
                    fifo_yumi_o = num_slots_p'(1) << grant_r;
                    if (word_cnt_r == last_word_lp) begin
                        state_n    = IDLE;
                        word_cnt_n = '0;
                        rr_ptr_n   = (grant_r == last_slot_lp) ? '0 : grant_r + 1'b1;
                    end else begin
                        word_cnt_n = word_cnt_r + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        credits_n = credits_n + cred_w_lp'(ret_ok);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= IDLE;
            rr_ptr_r   <= '0;
            grant_r    <= '0;
            word_cnt_r <= '0;
            credits_r  <= credits_max_lp;
        end else begin
            state_r    <= state_n;
            rr_ptr_r   <= rr_ptr_n;
            grant_r    <= grant_n;
            word_cnt_r <= word_cnt_n;
            credits_r  <= credits_n;
        end
    end

    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(credit_return_i && (credits_r == credits_max_lp)))
                else $error("credit returned while credits already full");
        end
    end

    assign slot_o    = grant_r;
    assign credits_o = credits_r;
    assign busy_o    = (state_r == SEND);

endmodule

// File: tb/tb_bsg_fifos_packet_arbiter.sv
// Directed bench for bsg_fifos_packet_arbiter: bench-side FIFO queues feed the DUT
// and a scoreboard of expected (slot, word) pairs is checked on every transfer.
module tb_bsg_fifos_packet_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [1:0]  fifo_v_i;
    logic [63:0] fifo_data_i;
    logic [1:0]  fifo_yumi_o;
    logic        v_o;
    logic [31:0] data_o;
    logic        ready_i;
    logic        credit_return_i;
    logic [0:0]  slot_o;
    logic [4:0]  credits_o;
    logic        busy_o;

    bsg_fifos_packet_arbiter #(
        .num_slots_p(2), .width_p(32), .packet_words_p(4), .credits_p(16)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .fifo_v_i(fifo_v_i), .fifo_data_i(fifo_data_i),
        .fifo_yumi_o(fifo_yumi_o), .v_o(v_o), .data_o(data_o), .ready_i(ready_i),
        .credit_return_i(credit_return_i), .slot_o(slot_o), .credits_o(credits_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [0:0]  slot;
        logic [31:0] data;
    } exp_t;

    logic [31:0] fq0[$];
    logic [31:0] fq1[$];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          xfers = 0;
    int          cyc = 0;
    int          first_x = -1;
    int          last_x = -1;
    int          stalls = 0;
    bit          toggle = 1'b0;
    bit          expect_gap = 1'b0;
    logic [1:0]  gap = 2'b00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [0:0] slot, input logic [31:0] base, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (slot == 1'b0) fq0.push_back(base + 32'(i));
            else              fq1.push_back(base + 32'(i));
        end
    endtask

    task automatic expect_words(input logic [0:0] slot, input logic [31:0] base, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.slot = slot;
            e.data = base + 32'(i);
            sb.push_back(e);
        end
    endtask

    // One clock cycle: drive at +1 after posedge, check at negedge, pop on yumi
    task automatic step();
        logic [1:0] y;
        fifo_v_i[0] = (fq0.size() > 0) && !gap[0];
        fifo_v_i[1] = (fq1.size() > 0) && !gap[1];
        fifo_data_i[31:0]  = (fq0.size() > 0) ? fq0[0] : 32'h0;
        fifo_data_i[63:32] = (fq1.size() > 0) ? fq1[0] : 32'h0;
        ready_i = toggle ? ~ready_i : 1'b1;
        @(negedge clk_i);
        y = fifo_yumi_o;
        if (expect_gap) begin
            chk("gap_v", 32'(v_o), 32'h0);
            chk("gap_slot", 32'(slot_o), 32'h0);
        end
        if (v_o) begin
            if (sb.size() == 0) chk("spurious_v", 32'(v_o), 32'h0);
            else begin
                chk("slot", 32'(slot_o), 32'(sb[0].slot));
                chk("data", data_o, sb[0].data);
            end
        end
        if (v_o && ready_i) begin
            if (sb.size() > 0) begin
                chk("yumi", 32'(y), 32'(2'b01 << sb[0].slot));
                void'(sb.pop_front());
            end
            xfers++;
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
        end else begin
            chk("yumi_idle", 32'(y), 32'h0);
            if (v_o) stalls++;
        end
        @(posedge clk_i);
        #1;
        cyc++;
        if (y[0] && fq0.size() > 0) void'(fq0.pop_front());
        if (y[1] && fq1.size() > 0) void'(fq1.pop_front());
    endtask

    task automatic run_until(input string tag, input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_done"}, 32'(sb.size()), 32'h0);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        credit_return_i = 1'b0;
        gap = 2'b00;
        toggle = 1'b0;
        expect_gap = 1'b0;
        fq0.delete();
        fq1.delete();
        sb.delete();
        fifo_v_i = 2'b00;
        fifo_data_i = '0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    initial begin
        int base;
        int n;
        reset_i = 1'b1;
        fifo_v_i = 2'b00;
        fifo_data_i = '0;
        ready_i = 1'b1;
        credit_return_i = 1'b0;
        #12;
        chk("rst_v", 32'(v_o), 32'h0);
        chk("rst_yumi", 32'(fifo_yumi_o), 32'h0);
        chk("rst_data", data_o, 32'h0);
        chk("rst_slot", 32'(slot_o), 32'h0);
        chk("rst_credits", 32'(credits_o), 32'd16);
        chk("rst_busy", 32'(busy_o), 32'h0);

        // Two back-to-back packets from slot 0
        do_reset();
        push(1'b0, 32'hA000_0000, 8);
        expect_words(1'b0, 32'hA000_0000, 8);
        first_x = -1;
        run_until("t1", 40);
        chk("t1_span", 32'(last_x - first_x), 32'd8);
        chk("t1_credits", 32'(credits_o), 32'd8);
        step();
        chk("t1_idle", 32'(busy_o), 32'h0);

        // Both slots valid: alternate 0,1,0,1 without interleaving
        do_reset();
        push(1'b0, 32'hB000_0000, 8);
        push(1'b1, 32'hC000_0000, 8);
        expect_words(1'b0, 32'hB000_0000, 4);
        expect_words(1'b1, 32'hC000_0000, 4);
        expect_words(1'b0, 32'hB000_0004, 4);
        expect_words(1'b1, 32'hC000_0004, 4);
        run_until("t2", 60);
        chk("t2_credits", 32'(credits_o), 32'd0);

        // Out of credits: stall until four words are returned
        push(1'b0, 32'hD000_0000, 4);
        expect_words(1'b0, 32'hD000_0000, 4);
        for (int i = 0; i < 5; i++) step();
        chk("t3_starved", 32'(sb.size()), 32'd4);
        chk("t3_busy", 32'(busy_o), 32'h0);
        credit_return_i = 1'b1;
        for (int i = 0; i < 4; i++) step();
        credit_return_i = 1'b0;
        chk("t3_credits4", 32'(credits_o), 32'd4);
        chk("t3_busy4", 32'(busy_o), 32'h0);
        run_until("t3", 20);
        chk("t3_credits0", 32'(credits_o), 32'd0);

        // Grant and credit return on the same edge at credits=5
        credit_return_i = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("t6_credits5", 32'(credits_o), 32'd5);
        push(1'b1, 32'hE100_0000, 4);
        expect_words(1'b1, 32'hE100_0000, 4);
        step();
        credit_return_i = 1'b0;
        chk("t6_credits2", 32'(credits_o), 32'd2);
        run_until("t6a", 20);

        // Downstream ready toggling
        do_reset();
        toggle = 1'b1;
        stalls = 0;
        push(1'b0, 32'h4000_0000, 4);
        expect_words(1'b0, 32'h4000_0000, 4);
        run_until("t4", 30);
        chk("t4_stalled", 32'(stalls > 0), 32'h1);
        toggle = 1'b0;

        // Bubble on the granted slot holds the grant
        do_reset();
        push(1'b0, 32'h5000_0000, 4);
        push(1'b1, 32'h5100_0000, 4);
        expect_words(1'b0, 32'h5000_0000, 4);
        expect_words(1'b1, 32'h5100_0000, 4);
        base = xfers;
        n = 0;
        while (xfers < base + 2 && n < 20) begin
            step();
            n++;
        end
        chk("t5_two_words", 32'(xfers - base), 32'd2);
        gap[0] = 1'b1;
        expect_gap = 1'b1;
        for (int i = 0; i < 3; i++) step();
        gap[0] = 1'b0;
        expect_gap = 1'b0;
        run_until("t5", 30);

        // Async reset mid-packet
        do_reset();
        push(1'b0, 32'h6000_0000, 4);
        expect_words(1'b0, 32'h6000_0000, 4);
        run_until("t6b_pre", 20);
        push(1'b1, 32'h6100_0000, 4);
        push(1'b0, 32'h6000_0004, 4);
        expect_words(1'b1, 32'h6100_0000, 2);
        base = xfers;
        n = 0;
        while (xfers < base + 2 && n < 20) begin
            step();
            n++;
        end
        chk("t6b_two_words", 32'(xfers - base), 32'd2);
        reset_i = 1'b1;
        #1;
        chk("t6b_v", 32'(v_o), 32'h0);
        chk("t6b_yumi", 32'(fifo_yumi_o), 32'h0);
        chk("t6b_credits", 32'(credits_o), 32'd16);
        chk("t6b_busy", 32'(busy_o), 32'h0);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        expect_words(1'b0, 32'h6000_0004, 4);
        run_until("t6b_post", 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
